// File: rtl/ecc_scrub_ctrl.sv
// Background ECC scrubber: walks every memory word, decodes it, writes back corrected
// codewords and tallies correctable / uncorrectable words for the pass.
module ecc_scrub_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int CW_WIDTH   = 13,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  abort_i,
   output logic                  mem_rd_en_o,
   output logic                  mem_wr_en_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [CW_WIDTH-1:0]   mem_wdata_o,
   input  logic [CW_WIDTH-1:0]   mem_rdata_i,
   output logic                  dec_en_o,
   output logic [39:0]           dec_codeword_o,
   input  logic [DATA_WIDTH-1:0] dec_data_i,
   input  logic                  dec_err_detected_i,
   input  logic                  dec_err_corrected_i,
   output logic                  enc_en_o,
   output logic [DATA_WIDTH-1:0] enc_data_o,
   input  logic [39:0]           enc_codeword_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  aborted_o,
   output logic [7:0]            corr_count_o,
   output logic [7:0]            uncorr_count_o,
   output logic                  uncorr_valid_o,
   output logic [ADDR_WIDTH-1:0] uncorr_addr_o
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_RD   = 4'd1,
      S_RDW  = 4'd2,
      S_DEC  = 4'd3,
      S_DECW = 4'd4,
      S_ENC  = 4'd5,
      S_ENCW = 4'd6,
      S_WR   = 4'd7,
      S_NXT  = 4'd8
   } state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [CW_WIDTH-1:0]   cw_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  abort_pend_q;
   logic                  wr_rec_q;
   logic                  rd_en_q;
   logic                  wr_en_q;
   logic                  dec_en_q;
   logic                  enc_en_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  aborted_q;
   logic [7:0]            corr_q;
   logic [7:0]            uncorr_q;
   logic                  uv_q;
   logic [ADDR_WIDTH-1:0] ua_q;
   logic [7:0]            corr_d;
   logic [7:0]            uncorr_d;
   logic                  enc_cw_unused_s;

   assign enc_cw_unused_s = ^enc_codeword_i[39:CW_WIDTH];

   // Saturating next values for the two error counters.
   always_comb begin
      if (corr_q == 8'hFF) begin
         corr_d = corr_q;
      end else begin
         corr_d = corr_q + 8'd1;
      end
      if (uncorr_q == 8'hFF) begin
         uncorr_d = uncorr_q;
      end else begin
         uncorr_d = uncorr_q + 8'd1;
      end
   end

   // Scrub sequencer; strobes are registered on entry to the state that owns them.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         addr_q       <= {ADDR_WIDTH{1'b0}};
         cw_q         <= {CW_WIDTH{1'b0}};
         data_q       <= {DATA_WIDTH{1'b0}};
         abort_pend_q <= 1'b0;
         wr_rec_q     <= 1'b0;
         rd_en_q      <= 1'b0;
         wr_en_q      <= 1'b0;
         dec_en_q     <= 1'b0;
         enc_en_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         corr_q       <= 8'd0;
         uncorr_q     <= 8'd0;
         uv_q         <= 1'b0;
         ua_q         <= {ADDR_WIDTH{1'b0}};
      end else begin
         rd_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         dec_en_q  <= 1'b0;
         enc_en_q  <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         if (abort_i && (state_q != S_IDLE)) begin
            abort_pend_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q      <= S_RD;
                  addr_q       <= {ADDR_WIDTH{1'b0}};
                  corr_q       <= 8'd0;
                  uncorr_q     <= 8'd0;
                  uv_q         <= 1'b0;
                  ua_q         <= {ADDR_WIDTH{1'b0}};
                  abort_pend_q <= 1'b0;
                  busy_q       <= 1'b1;
                  rd_en_q      <= 1'b1;
               end
            end
            S_RD: begin
               state_q <= S_RDW;
            end
            S_RDW: begin
               cw_q     <= mem_rdata_i;
               dec_en_q <= 1'b1;
               state_q  <= S_DEC;
            end
            S_DEC: begin
               state_q <= S_DECW;
            end
            S_DECW: begin
               data_q <= dec_data_i;
               if (dec_err_corrected_i) begin
                  enc_en_q <= 1'b1;
                  state_q  <= S_ENC;
               end else if (dec_err_detected_i) begin
                  uncorr_q <= uncorr_d;
                  if (!uv_q) begin
                     uv_q <= 1'b1;
                     ua_q <= addr_q;
                  end
                  state_q <= S_NXT;
               end else begin
                  state_q <= S_NXT;
               end
            end
            S_ENC: begin
               state_q <= S_ENCW;
            end
            S_ENCW: begin
               cw_q     <= enc_codeword_i[CW_WIDTH-1:0];
               wr_en_q  <= 1'b1;
               wr_rec_q <= 1'b0;
               state_q  <= S_WR;
            end
            // WR spends one recovery cycle after the write strobe before moving on.
            S_WR: begin
               if (!wr_rec_q) begin
                  corr_q   <= corr_d;
                  wr_rec_q <= 1'b1;
               end else begin
                  wr_rec_q <= 1'b0;
                  state_q  <= S_NXT;
               end
            end
            S_NXT: begin
               if (abort_pend_q || abort_i) begin
                  abort_pend_q <= 1'b0;
                  aborted_q    <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= S_IDLE;
               end else if (addr_q == {ADDR_WIDTH{1'b1}}) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  addr_q  <= addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                  rd_en_q <= 1'b1;
                  state_q <= S_RD;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mem_rd_en_o    = rd_en_q;
   assign mem_wr_en_o    = wr_en_q;
   assign mem_addr_o     = addr_q;
   assign mem_wdata_o    = cw_q;
   assign dec_en_o       = dec_en_q;
   assign dec_codeword_o = {{(40-CW_WIDTH){1'b0}}, cw_q};
   assign enc_en_o       = enc_en_q;
   assign enc_data_o     = data_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign aborted_o      = aborted_q;
   assign corr_count_o   = corr_q;
   assign uncorr_count_o = uncorr_q;
   assign uncorr_valid_o = uv_q;
   assign uncorr_addr_o  = ua_q;

endmodule
